// File: rtl/ball_vertical_motion_pkg.sv
// ball_vertical_motion_pkg: shared defaults, FSM states and geometry helpers for the vertical ball engine
package ball_vertical_motion_pkg;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_BALL_SIZE = 8;
  localparam int DEF_MAX_SPEED = 7;
  typedef enum logic {PARKED, MOVING} ball_state_e;
  function automatic int max_pos(input int v_visible, input int ball_size);
    return v_visible - ball_size;
  endfunction
  function automatic int center_pos(input int v_visible, input int ball_size);
    return (v_visible - ball_size) / 2;
  endfunction
endpackage

// File: rtl/ball_vertical_motion_line_counter.sv
// vid_line_counter: visible line counter plus registered VBlank rising-edge frame tick
module vid_line_counter
  import ball_vertical_motion_pkg::*;
#(
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  localparam int PW = $clog2(V_VISIBLE + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_HReset,
  input  logic          i_VBlank,
  output logic [PW-1:0] line_cnt,
  output logic          frame_tick
);
  logic vblank_q;
  // count lines during the visible area, saturating; the previous VBlank feeds the edge detect
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      line_cnt <= '0;
      vblank_q <= 1'b1;
    end else begin
      vblank_q <= i_VBlank;
      if (i_VBlank) line_cnt <= '0;
      else if (i_HReset && line_cnt != PW'(V_VISIBLE)) line_cnt <= line_cnt + 1'b1;
    end
  end
  assign frame_tick = i_VBlank & ~vblank_q;
endmodule

// File: rtl/ball_vertical_motion.sv
// ball_vertical_motion: per-frame vertical ball position, wall reflection and line-gated video
module ball_vertical_motion
  import ball_vertical_motion_pkg::*;
#(
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int BALL_SIZE = DEF_BALL_SIZE,
  parameter int MAX_SPEED = DEF_MAX_SPEED,
  parameter int SPEED_W   = 3,
  localparam int PW = $clog2(V_VISIBLE + 1)
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_HReset,
  input  logic               i_VBlank,
  input  logic               i_Serve,
  input  logic               i_ServeDir,
  input  logic               i_Flip,
  input  logic               i_Stop,
  input  logic [SPEED_W-1:0] i_Speed,
  output logic               o_Video,
  output logic [PW-1:0]      o_Pos,
  output logic               o_Dir,
  output logic               o_Moving,
  output logic               o_WallHit
);
  localparam int AW = PW + 1;
  localparam logic [AW-1:0] MAX_POS = AW'(max_pos(V_VISIBLE, BALL_SIZE));
  localparam logic [AW-1:0] CENTER  = AW'(center_pos(V_VISIBLE, BALL_SIZE));
  localparam logic [AW-1:0] SIZE_A  = AW'(BALL_SIZE);
  localparam logic [AW-1:0] MAX_S   = AW'(MAX_SPEED);
  ball_state_e   state_q, state_d;
  logic [PW-1:0] pos_q, pos_d, line_cnt;
  logic          dir_q, dir_d, hit_q, hit_d, frame_tick;
  logic          serve_p, serve_dir_p, flip_p, stop_p;
  logic          eff_serve, eff_dir, eff_flip, eff_stop, move_dir;
  logic [AW-1:0] pos_a, speed_a, s, n, down_pos, up_pos;
  vid_line_counter #(.V_VISIBLE(V_VISIBLE)) u_lines (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_HReset(i_HReset), .i_VBlank(i_VBlank),
    .line_cnt(line_cnt), .frame_tick(frame_tick)
  );
  assign pos_a     = AW'(pos_q);
  assign speed_a   = AW'(i_Speed);
  assign s         = speed_a > MAX_S ? MAX_S : speed_a;
  assign n         = pos_a + s;
  assign down_pos  = n > MAX_POS ? (MAX_POS << 1) - n : n;
  assign up_pos    = s > pos_a ? s - pos_a : pos_a - s;
  assign eff_serve = serve_p | i_Serve;
  assign eff_dir   = i_Serve ? i_ServeDir : serve_dir_p;
  assign eff_flip  = flip_p | i_Flip;
  assign eff_stop  = stop_p | i_Stop;
  assign move_dir  = dir_q ^ eff_flip;
  // one update per frame tick: stop beats serve beats flip beats plain motion
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    hit_d   = 1'b0;
    if (frame_tick) begin
      if (eff_stop) state_d = PARKED;
      else if (eff_serve) begin
        state_d = MOVING;
        pos_d   = PW'(CENTER);
        dir_d   = eff_dir;
      end else if (state_q == MOVING) begin
        pos_d = PW'(move_dir ? down_pos : up_pos);
        hit_d = move_dir ? n > MAX_POS : s > pos_a;
        dir_d = hit_d ? ~move_dir : move_dir;
      end
    end
  end
  // FSM state, position/direction and the one-cycle wall hit pulse
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= PARKED;
      pos_q   <= PW'(CENTER);
      dir_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      hit_q   <= hit_d;
    end
  end
  // sticky request flags, consumed on the frame tick
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      serve_p     <= 1'b0;
      serve_dir_p <= 1'b0;
      flip_p      <= 1'b0;
      stop_p      <= 1'b0;
    end else if (frame_tick) begin
      serve_p     <= 1'b0;
      serve_dir_p <= 1'b0;
      flip_p      <= 1'b0;
      stop_p      <= 1'b0;
    end else begin
      serve_p     <= serve_p | i_Serve;
      serve_dir_p <= i_Serve ? i_ServeDir : serve_dir_p;
      flip_p      <= flip_p | i_Flip;
      stop_p      <= stop_p | i_Stop;
    end
  end
  assign o_Video   = ~i_VBlank && AW'(line_cnt) > pos_a && AW'(line_cnt) <= pos_a + SIZE_A;
  assign o_Pos     = pos_q;
  assign o_Dir     = dir_q;
  assign o_Moving  = state_q == MOVING;
  assign o_WallHit = hit_q;
endmodule

// File: tb/tb_ball_vertical_motion.sv
// tb_ball_vertical_motion: table, directed and randomized checks against a frame-level ball model
module tb_ball_vertical_motion;
  localparam int MAXS = 5;
  localparam int MAXP = 472;
  localparam int CTR  = 236;
  logic       i_Clk = 1'b0, i_Rst_n = 1'b0, i_HReset = 1'b0, i_VBlank = 1'b1;
  logic       i_Serve = 1'b0, i_ServeDir = 1'b0, i_Flip = 1'b0, i_Stop = 1'b0;
  logic [2:0] i_Speed = 3'd0;
  logic       o_Video, o_Dir, o_Moving, o_WallHit;
  logic [8:0] o_Pos;
  int n_chk = 0, n_fail = 0;
  int m_pos, m_dir, m_mov, m_hit, p_serve, p_sdir, p_flip, p_stop, last_hit;
  typedef struct {
    bit serve, sdir, flip, stop;
    int speed, pos, dir, mov, hit;
  } vec_t;
  vec_t tbl[11];
  ball_vertical_motion #(.MAX_SPEED(MAXS)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_HReset(i_HReset), .i_VBlank(i_VBlank),
    .i_Serve(i_Serve), .i_ServeDir(i_ServeDir), .i_Flip(i_Flip), .i_Stop(i_Stop),
    .i_Speed(i_Speed), .o_Video(o_Video), .o_Pos(o_Pos), .o_Dir(o_Dir),
    .o_Moving(o_Moving), .o_WallHit(o_WallHit)
  );
  always #5 i_Clk = ~i_Clk;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pos = CTR; m_dir = 0; m_mov = 0; m_hit = 0;
    p_serve = 0; p_sdir = 0; p_flip = 0; p_stop = 0;
  endtask
  task automatic model_tick(input int spd);
    int s;
    s = spd > MAXS ? MAXS : spd;
    m_hit = 0;
    if (p_stop) m_mov = 0;
    else if (p_serve) begin
      m_pos = CTR; m_dir = p_sdir; m_mov = 1;
    end else if (m_mov) begin
      if (p_flip) m_dir = 1 - m_dir;
      if (m_dir == 1) begin
        if (m_pos + s > MAXP) begin
          m_pos = 2 * MAXP - (m_pos + s); m_dir = 0; m_hit = 1;
        end else m_pos = m_pos + s;
      end else begin
        if (s > m_pos) begin
          m_pos = s - m_pos; m_dir = 1; m_hit = 1;
        end else m_pos = m_pos - s;
      end
    end
    p_serve = 0; p_sdir = 0; p_flip = 0; p_stop = 0;
  endtask
  task automatic send(input bit serve, input bit sdir, input bit flip, input bit stop);
    i_Serve = serve; i_ServeDir = sdir; i_Flip = flip; i_Stop = stop;
    @(posedge i_Clk); #1;
    i_Serve = 0; i_ServeDir = 0; i_Flip = 0; i_Stop = 0;
    if (serve) begin p_serve = 1; p_sdir = sdir; end
    if (flip) p_flip = 1;
    if (stop) p_stop = 1;
  endtask
  task automatic frame(input int nl, input bit chk_video);
    i_VBlank = 0; i_HReset = 1;
    for (int k = 1; k <= nl; k++) begin
      @(posedge i_Clk); #1;
      if (chk_video) check("video_line", int'(o_Video), int'(k > m_pos && k <= m_pos + 8));
    end
    i_HReset = 0; i_VBlank = 1;
    @(posedge i_Clk); #1;
    model_tick(int'(i_Speed));
    last_hit = int'(o_WallHit);
    check("pos", int'(o_Pos), m_pos);
    check("dir", int'(o_Dir), m_dir);
    check("moving", int'(o_Moving), m_mov);
    check("wallhit", last_hit, m_hit);
    check("video_vblank", int'(o_Video), 0);
    @(posedge i_Clk); #1;
    check("wallhit_len", int'(o_WallHit), 0);
  endtask
  initial begin
    tbl[0]  = '{0, 0, 0, 0, 3, 236, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 3, 236, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 5, 231, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 7, 226, 0, 1, 0};
    tbl[4]  = '{0, 0, 1, 0, 4, 230, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 230, 1, 1, 0};
    tbl[6]  = '{1, 0, 1, 1, 3, 230, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 6, 230, 1, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 2, 236, 1, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 2, 238, 1, 1, 0};
    tbl[10] = '{0, 0, 0, 1, 2, 238, 1, 0, 0};
    model_reset();
    repeat (3) @(posedge i_Clk);
    #1;
    check("rst_pos", int'(o_Pos), CTR);
    check("rst_dir", int'(o_Dir), 0);
    check("rst_moving", int'(o_Moving), 0);
    check("rst_video", int'(o_Video), 0);
    check("rst_wallhit", int'(o_WallHit), 0);
    i_Rst_n = 1;
    @(posedge i_Clk); #1;
    for (int f = 0; f < 3; f++) frame(480, 1);
    check("idle_pos", int'(o_Pos), 236);
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].serve || tbl[i].flip || tbl[i].stop) send(tbl[i].serve, tbl[i].sdir, tbl[i].flip, tbl[i].stop);
      i_Speed = 3'(tbl[i].speed);
      frame(3, 0);
      check($sformatf("tbl%0d_pos", i), int'(o_Pos), tbl[i].pos);
      check($sformatf("tbl%0d_dir", i), int'(o_Dir), tbl[i].dir);
      check($sformatf("tbl%0d_moving", i), int'(o_Moving), tbl[i].mov);
      check($sformatf("tbl%0d_hit", i), last_hit, tbl[i].hit);
    end
    send(1, 1, 0, 0);
    i_Speed = 3'd5;
    for (int k = 1; k <= 48; k++) begin
      frame(4, 0);
      check("down_ramp", int'(o_Pos), 236 + 5 * (k - 1));
    end
    frame(4, 0);
    check("bottom_pos", int'(o_Pos), 468);
    check("bottom_dir", int'(o_Dir), 0);
    check("bottom_hit", last_hit, 1);
    for (int k = 0; k < 93; k++) frame(2, 0);
    check("up_pos3", int'(o_Pos), 3);
    i_Speed = 3'd3;
    frame(2, 0);
    check("land_zero_pos", int'(o_Pos), 0);
    check("land_zero_hit", last_hit, 0);
    i_Speed = 3'd0;
    frame(2, 0);
    check("speed0_pos", int'(o_Pos), 0);
    check("speed0_hit", last_hit, 0);
    i_Speed = 3'd7;
    frame(2, 0);
    check("top_pos", int'(o_Pos), 5);
    check("top_dir", int'(o_Dir), 1);
    check("top_hit", last_hit, 1);
    send(1, 0, 0, 0);
    i_VBlank = 0; i_HReset = 1;
    repeat (3) @(posedge i_Clk);
    #2 i_Rst_n = 0;
    #1;
    model_reset();
    check("midrst_pos", int'(o_Pos), CTR);
    check("midrst_dir", int'(o_Dir), 0);
    check("midrst_moving", int'(o_Moving), 0);
    check("midrst_video", int'(o_Video), 0);
    @(posedge i_Clk); #1;
    i_Rst_n = 1;
    i_HReset = 0; i_VBlank = 1;
    @(posedge i_Clk); #1;
    frame(10, 1);
    check("midrst_serve_dropped", int'(o_Moving), 0);
    send(1, 1, 0, 0);
    for (int f = 0; f < 40; f++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r < 7) send(r < 3, 1'($urandom_range(0, 1)), r >= 3 && r < 6, r == 6);
      i_Speed = 3'($urandom_range(0, 7));
      frame(int'($urandom_range(1, 480)), 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
